// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Data-phase state encodings and the memory access-type codes live here.
package vscale_mem_arbiter_pkg;

  localparam int XPR_LEN        = 32;
  localparam int MEM_TYPE_WIDTH = 3;
  localparam int DP_STATE_WIDTH = 2;

  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LB  = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LH  = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LW  = 3'd2;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LD  = 3'd3;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LBU = 3'd4;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LHU = 3'd5;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LWU = 3'd6;

  // Owner of the data phase currently on the memory.
  typedef enum logic [DP_STATE_WIDTH-1:0] {
    DP_IDLE   = 2'd0,
    DP_DATA_I = 2'd1,
    DP_DATA_D = 2'd2
  } dp_state_t;

  typedef struct packed {
    logic                      en;
    logic                      wen;
    logic [MEM_TYPE_WIDTH-1:0] size;
    logic [XPR_LEN-1:0]        addr;
  } mem_req_t;

  // Address phase presented on behalf of the fetch port.
  function automatic mem_req_t fetch_req(input logic [XPR_LEN-1:0] addr);
    mem_req_t r;
    r.en   = 1'b1;
    r.wen  = 1'b0;
    r.size = MEM_TYPE_LW;
    r.addr = addr;
    return r;
  endfunction

endpackage

// File: rtl/vscale_mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the pipeline plus memory around it.
interface vscale_mem_arbiter_if;
  import vscale_mem_arbiter_pkg::*;

  logic [XPR_LEN-1:0]        imem_addr;
  logic [XPR_LEN-1:0]        imem_rdata;
  logic                      imem_wait;
  logic                      imem_badmem_e;

  logic                      dmem_en;
  logic                      dmem_wen;
  logic [MEM_TYPE_WIDTH-1:0] dmem_size;
  logic [XPR_LEN-1:0]        dmem_addr;
  logic [XPR_LEN-1:0]        dmem_wdata_delayed;
  logic [XPR_LEN-1:0]        dmem_rdata;
  logic                      dmem_wait;
  logic                      dmem_badmem_e;

  logic                      mem_en;
  logic                      mem_wen;
  logic [MEM_TYPE_WIDTH-1:0] mem_size;
  logic [XPR_LEN-1:0]        mem_addr;
  logic [XPR_LEN-1:0]        mem_wdata;
  logic [XPR_LEN-1:0]        mem_rdata;
  logic                      mem_wait;
  logic                      mem_badmem_e;

  modport slave (
    input  imem_addr,
    output imem_rdata, imem_wait, imem_badmem_e,
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    output dmem_rdata, dmem_wait, dmem_badmem_e,
    output mem_en, mem_wen, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_wait, mem_badmem_e
  );

  modport master (
    output imem_addr,
    input  imem_rdata, imem_wait, imem_badmem_e,
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    input  dmem_rdata, dmem_wait, dmem_badmem_e,
    input  mem_en, mem_wen, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_wait, mem_badmem_e
  );

endinterface

// File: rtl/vscale_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module vscale_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vscale_mem_arbiter.sv
// Arbitrates one pipelined memory between fetch and data ports; data wins.
// Tracks the data-phase owner to route rdata, wait and error back correctly.
module vscale_mem_arbiter
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  vscale_mem_arbiter_if.slave  bus,
  output logic [CNT_WIDTH-1:0] conflict_count
);

  dp_state_t dp_state;
  logic      dp_wen;
  logic      addr_ok;
  logic      grant_d;
  logic      grant_i;
  mem_req_t  mem_req;

  // A new address is accepted only when no data phase is being stretched.
  always_comb begin
    addr_ok = (dp_state == DP_IDLE) | ~bus.mem_wait;
    grant_d = ~reset & addr_ok & bus.dmem_en;
    grant_i = ~reset & addr_ok & ~bus.dmem_en;
  end

  // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_req = '0;
    if (grant_d) begin
      mem_req.en   = 1'b1;
      mem_req.wen  = bus.dmem_wen;
      mem_req.size = bus.dmem_size;
      mem_req.addr = bus.dmem_addr;
    end else if (grant_i) begin
      mem_req = fetch_req(bus.imem_addr);
    end
  end

  assign bus.mem_en   = mem_req.en;
  assign bus.mem_wen  = mem_req.wen;
  assign bus.mem_size = mem_req.size;
  assign bus.mem_addr = mem_req.addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_state <= DP_IDLE;
      dp_wen   <= 1'b0;
    end else if (grant_d) begin
      dp_state <= DP_DATA_D;
      dp_wen   <= bus.dmem_wen;
    end else if (grant_i) begin
      dp_state <= DP_DATA_I;
      dp_wen   <= 1'b0;
    end
  end

  // Fetch stalls when it loses arbitration or its own data phase is stretched.
  always_comb begin
    bus.imem_wait     = 1'b0;
    bus.dmem_wait     = 1'b0;
    bus.imem_badmem_e = 1'b0;
    bus.dmem_badmem_e = 1'b0;
    if (!reset) begin
      bus.imem_wait     = ~addr_ok | bus.dmem_en
                          | ((dp_state == DP_DATA_I) & bus.mem_wait);
      bus.dmem_wait     = (dp_state == DP_DATA_D) & bus.mem_wait;
      bus.imem_badmem_e = bus.mem_badmem_e & (dp_state == DP_DATA_I) & ~bus.mem_wait;
      bus.dmem_badmem_e = bus.mem_badmem_e & (dp_state == DP_DATA_D) & ~bus.mem_wait;
    end
  end

  assign bus.imem_rdata = bus.mem_rdata;
  assign bus.dmem_rdata = bus.mem_rdata;
  assign bus.mem_wdata  = ((dp_state == DP_DATA_D) && dp_wen) ? bus.dmem_wdata_delayed
                                                               : '0;

  vscale_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_conflict_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (grant_d),
    .count (conflict_count)
  );

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Scoreboard bench for vscale_mem_arbiter: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_vscale_mem_arbiter;
  import vscale_mem_arbiter_pkg::*;

  localparam int CW = 4;

  typedef enum int {
    S_MEM_EN, S_MEM_WEN, S_MEM_SIZE, S_MEM_ADDR, S_MEM_WDATA,
    S_IMEM_WAIT, S_DMEM_WAIT, S_IBAD, S_DBAD, S_IRDATA, S_DRDATA, S_CNT
  } sig_t;

  typedef struct {
    int          cyc;
    string       name;
    sig_t        sig;
    logic [31:0] val;
  } exp_t;

  logic           clk;
  logic           reset;
  logic [CW-1:0]  conflict_count;
  int             cyc;
  int             n_cmp;
  int             n_bad;
  exp_t           sb[$];

  vscale_mem_arbiter_if bus ();

  vscale_mem_arbiter #(
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .conflict_count (conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_sig(input sig_t s);
    case (s)
      S_MEM_EN:    return {31'd0, bus.mem_en};
      S_MEM_WEN:   return {31'd0, bus.mem_wen};
      S_MEM_SIZE:  return {29'd0, bus.mem_size};
      S_MEM_ADDR:  return bus.mem_addr;
      S_MEM_WDATA: return bus.mem_wdata;
      S_IMEM_WAIT: return {31'd0, bus.imem_wait};
      S_DMEM_WAIT: return {31'd0, bus.dmem_wait};
      S_IBAD:      return {31'd0, bus.imem_badmem_e};
      S_DBAD:      return {31'd0, bus.dmem_badmem_e};
      S_IRDATA:    return bus.imem_rdata;
      S_DRDATA:    return bus.dmem_rdata;
      default:     return {28'd0, conflict_count};
    endcase
  endfunction

  task automatic expect_sig(input string name, input sig_t s, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.sig  = s;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_d(input logic en, input logic wen, input logic [2:0] size,
                         input logic [31:0] addr);
    bus.dmem_en   = en;
    bus.dmem_wen  = wen;
    bus.dmem_size = size;
    bus.dmem_addr = addr;
  endtask

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else begin
        act = get_sig(e.sig);
        if (act !== e.val) begin
          n_bad++;
          $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", e.name, cyc, act, e.val);
        end
      end
    end
  end

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.imem_addr          = 32'h0;
    bus.dmem_wdata_delayed = 32'h0;
    bus.mem_rdata          = 32'h0;
    bus.mem_wait           = 1'b0;
    bus.mem_badmem_e       = 1'b0;
    drive_d(1'b1, 1'b0, MEM_TYPE_LW, 32'h0);
    bus.mem_badmem_e = 1'b1;

    // Reset held: every request and error indication suppressed.
    step();
    expect_sig("rst_mem_en",   S_MEM_EN,    32'd0);
    expect_sig("rst_imem_wait", S_IMEM_WAIT, 32'd0);
    expect_sig("rst_dmem_wait", S_DMEM_WAIT, 32'd0);
    expect_sig("rst_ibad",     S_IBAD,      32'd0);
    expect_sig("rst_dbad",     S_DBAD,      32'd0);

    // A: fetch only from IDLE.
    step();
    reset = 1'b0;
    drive_d(1'b0, 1'b0, MEM_TYPE_LW, 32'h0);
    bus.mem_badmem_e = 1'b0;
    bus.imem_addr    = 32'h100;
    bus.mem_rdata    = 32'h0000_0013;
    expect_sig("rst_cnt",      S_CNT,       32'd0);
    expect_sig("f_mem_en",     S_MEM_EN,    32'd1);
    expect_sig("f_mem_addr",   S_MEM_ADDR,  32'h100);
    expect_sig("f_mem_wen",    S_MEM_WEN,   32'd0);
    expect_sig("f_mem_size",   S_MEM_SIZE,  32'(MEM_TYPE_LW));
    expect_sig("f_imem_wait",  S_IMEM_WAIT, 32'd0);

    // B: fetch data phase returns.
    step();
    bus.imem_addr = 32'h104;
    expect_sig("f_imem_rdata", S_IRDATA,    32'h13);
    expect_sig("f_cnt",        S_CNT,       32'd0);

    // C: load conflicts with fetch 0x108.
    step();
    drive_d(1'b1, 1'b0, MEM_TYPE_LBU, 32'h2004);
    bus.imem_addr = 32'h108;
    bus.mem_rdata = 32'h1111_1111;
    expect_sig("ld_mem_addr",  S_MEM_ADDR,  32'h2004);
    expect_sig("ld_mem_size",  S_MEM_SIZE,  32'(MEM_TYPE_LBU));
    expect_sig("ld_imem_wait", S_IMEM_WAIT, 32'd1);
    expect_sig("ld_prev_fetch", S_IRDATA,   32'h1111_1111);

    // D: load data phase, fetch 0x108 issued.
    step();
    drive_d(1'b0, 1'b0, MEM_TYPE_LW, 32'h0);
    bus.mem_rdata = 32'hCAFE_F00D;
    expect_sig("ld_dmem_rdata", S_DRDATA,    32'hCAFE_F00D);
    expect_sig("ld_dmem_wait", S_DMEM_WAIT, 32'd0);
    expect_sig("ld_refetch",   S_MEM_ADDR,  32'h108);
    expect_sig("ld_imem_wait2", S_IMEM_WAIT, 32'd0);
    expect_sig("ld_cnt",       S_CNT,       32'd1);
    expect_sig("ld_no_wdata",  S_MEM_WDATA, 32'd0);

    // E: store address phase.
    step();
    drive_d(1'b1, 1'b1, MEM_TYPE_LW, 32'h3000);
    bus.imem_addr          = 32'h10c;
    bus.dmem_wdata_delayed = 32'h5555_5555;
    expect_sig("st_mem_wen",   S_MEM_WEN,   32'd1);
    expect_sig("st_mem_addr",  S_MEM_ADDR,  32'h3000);
    expect_sig("st_wdata_addr", S_MEM_WDATA, 32'd0);

    // F, G: store data phase stretched by two wait cycles.
    for (int i = 0; i < 2; i++) begin
      step();
      drive_d(1'b0, 1'b0, MEM_TYPE_LW, 32'h0);
      bus.dmem_wdata_delayed = 32'hDEAD_BEEF;
      bus.mem_wait           = 1'b1;
      expect_sig("st_wdata_stall", S_MEM_WDATA, 32'hDEAD_BEEF);
      expect_sig("st_dmem_wait",  S_DMEM_WAIT, 32'd1);
      expect_sig("st_imem_wait",  S_IMEM_WAIT, 32'd1);
      expect_sig("st_mem_en",     S_MEM_EN,    32'd0);
      expect_sig("st_cnt",        S_CNT,       32'd2);
    end

    // H: store completes, fetch 0x10c issued back-to-back.
    step();
    bus.mem_wait = 1'b0;
    expect_sig("st_wdata_last", S_MEM_WDATA, 32'hDEAD_BEEF);
    expect_sig("st_dmem_wait_last", S_DMEM_WAIT, 32'd0);
    expect_sig("st_next_fetch", S_MEM_ADDR,  32'h10c);
    expect_sig("st_next_en",    S_MEM_EN,    32'd1);

    // I: error during fetch data phase; load 0x2008 requested.
    step();
    bus.dmem_wdata_delayed = 32'h0;
    bus.mem_badmem_e = 1'b1;
    drive_d(1'b1, 1'b0, MEM_TYPE_LW, 32'h2008);
    expect_sig("err_i_ibad",  S_IBAD,      32'd1);
    expect_sig("err_i_dbad",  S_DBAD,      32'd0);
    expect_sig("err_i_wdata", S_MEM_WDATA, 32'd0);

    // J: error during data data phase.
    step();
    drive_d(1'b0, 1'b0, MEM_TYPE_LW, 32'h0);
    bus.imem_addr = 32'h110;
    expect_sig("err_d_ibad", S_IBAD, 32'd0);
    expect_sig("err_d_dbad", S_DBAD, 32'd1);
    expect_sig("err_d_cnt",  S_CNT,  32'd3);

    // K: stalled fetch phase; error masked, load 0x2010 refused.
    step();
    bus.mem_wait = 1'b1;
    drive_d(1'b1, 1'b0, MEM_TYPE_LW, 32'h2010);
    expect_sig("stall_i_ibad",  S_IBAD,      32'd0);
    expect_sig("stall_i_iwait", S_IMEM_WAIT, 32'd1);
    expect_sig("stall_i_dwait", S_DMEM_WAIT, 32'd0);
    expect_sig("stall_i_en",    S_MEM_EN,    32'd0);
    expect_sig("stall_i_cnt",   S_CNT,       32'd3);

    // L: stall ends, pending load granted immediately.
    step();
    bus.mem_wait     = 1'b0;
    bus.mem_badmem_e = 1'b0;
    expect_sig("pend_d_addr",  S_MEM_ADDR,  32'h2010);
    expect_sig("pend_d_en",    S_MEM_EN,    32'd1);
    expect_sig("pend_d_iwait", S_IMEM_WAIT, 32'd1);

    // M: fetch follows one cycle later.
    step();
    drive_d(1'b0, 1'b0, MEM_TYPE_LW, 32'h0);
    expect_sig("pend_i_addr",  S_MEM_ADDR,  32'h110);
    expect_sig("pend_i_iwait", S_IMEM_WAIT, 32'd0);
    expect_sig("pend_cnt",     S_CNT,       32'd4);

    // Saturation: 20 consecutive data requests from count 4.
    for (int i = 0; i < 20; i++) begin
      step();
      drive_d(1'b1, 1'b0, MEM_TYPE_LW, 32'h4000 + 32'(4 * i));
      expect_sig($sformatf("sat_cnt_%0d", i), S_CNT, (4 + i > 15) ? 32'd15 : 32'(4 + i));
    end
    step();
    expect_sig("sat_hold", S_CNT, 32'd15);

    // Reset during a stalled store data phase.
    step();
    drive_d(1'b1, 1'b1, MEM_TYPE_LW, 32'h3004);
    bus.imem_addr = 32'h200;
    step();
    drive_d(1'b0, 1'b0, MEM_TYPE_LW, 32'h0);
    bus.mem_wait = 1'b1;
    expect_sig("rs_dmem_wait", S_DMEM_WAIT, 32'd1);
    step();
    reset = 1'b1;
    expect_sig("rs_mem_en",    S_MEM_EN,    32'd0);
    expect_sig("rs_dwait",     S_DMEM_WAIT, 32'd0);
    expect_sig("rs_iwait",     S_IMEM_WAIT, 32'd0);
    step();
    expect_sig("rs_cnt",       S_CNT,       32'd0);
    expect_sig("rs_mem_en2",   S_MEM_EN,    32'd0);
    step();
    reset = 1'b0;
    expect_sig("post_rst_en",    S_MEM_EN,    32'd1);
    expect_sig("post_rst_addr",  S_MEM_ADDR,  32'h200);
    expect_sig("post_rst_iwait", S_IMEM_WAIT, 32'd0);
    expect_sig("post_rst_dwait", S_DMEM_WAIT, 32'd0);
    step();
    expect_sig("post_rst_istall", S_IMEM_WAIT, 32'd1);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, 0 required", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
